wbu_pipe: RTL

- Registered, handshaked writeback stage; successor to the purely combinational writeback mux.
- Accepts one retiring instruction per cycle from EXU/LSU, selects among N result sources, aligns and sign/zero-extends load data, and waits for multi-cycle load responses.
- Drives the register-file write port, a forwarding tap and a retire counter.
- Sits between the LSU and the register file at the end of the pipeline.

---
 rtl/wbu_pipe_pkg.sv | 24 ++
 rtl/wbu_pipe_ld_ext.sv | 46 ++++
 rtl/wbu_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wbu_pipe_pkg.sv
// rtl/wbu_pipe_pkg.sv - shared encodings for the writeback stage
package wbu_pipe_pkg;

  // result source select
  localparam logic [1:0] SRC_EXU  = 2'd0;
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_CSR  = 2'd2;
  localparam logic [1:0] SRC_PC4  = 2'd3;

  // load funct3 encodings
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_LD
  } wbu_state_e;

endpackage

// File: rtl/wbu_pipe_ld_ext.sv
// rtl/wbu_pipe_ld_ext.sv - load lane select and sign/zero extension
module wbu_ld_ext
  import wbu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      size,
  input  logic [2:0]      off,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [2:0]  boff;
  logic [5:0]  b_sh;
  logic [5:0]  h_sh;
  logic [5:0]  w_sh;
  logic [7:0]  b_val;
  logic [15:0] h_val;
  logic [31:0] w_val;

  // Pick the addressed lane, then extend according to funct3; a 32-bit
  // datapath ignores off[2] because the word is the whole bus.
  always_comb begin
    boff    = (XLEN == 64) ? off : {1'b0, off[1:0]};
    b_sh    = {boff, 3'b000};
    h_sh    = {boff[2:1], 4'b0000};
    w_sh    = {boff[2], 5'b00000};
    b_val   = 8'(rdata >> b_sh);
    h_val   = 16'(rdata >> h_sh);
    w_val   = 32'(rdata >> w_sh);
    data    = '0;
    illegal = 1'b0;
    case (size)
      LD_LB:  data = XLEN'($signed(b_val));
      LD_LH:  data = XLEN'($signed(h_val));
      LD_LW:  data = XLEN'($signed(w_val));
      LD_LD:  if (XLEN == 64) data = rdata; else illegal = 1'b1;
      LD_LBU: data = XLEN'(b_val);
      LD_LHU: data = XLEN'(h_val);
      LD_LWU: if (XLEN == 64) data = XLEN'(w_val); else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wbu_pipe.sv
// rtl/wbu_pipe.sv - registered handshaked writeback stage
module wbu_pipe
  import wbu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_src,
  input  logic [RAW-1:0]   in_rd,
  input  logic             in_wen,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_exu_res,
  input  logic [XLEN-1:0]  in_csr_res,
  input  logic [2:0]       in_ld_size,
  input  logic [2:0]       in_ld_off,
  input  logic             lsu_rvalid,
  input  logic [XLEN-1:0]  lsu_rdata,
  output logic             rf_wen,
  output logic [RAW-1:0]   rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [RAW-1:0]   fwd_rd,
  output logic             retire_valid,
  output logic [XLEN-1:0]  retire_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             ld_err
);

  wbu_state_e state, state_nxt;

  logic [RAW-1:0]  ld_rd;
  logic            ld_wen;
  logic [XLEN-1:0] ld_pc;
  logic [2:0]      ld_size;
  logic [2:0]      ld_off;

  logic            capture_ld;
  logic            retire_now;
  logic            wb_wen;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;
  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;

  wbu_ld_ext #(.XLEN(XLEN)) u_ld_ext (
    .rdata   (lsu_rdata),
    .size    (ld_size),
    .off     (ld_off),
    .data    (ext_data),
    .illegal (ext_illegal)
  );

  // State register; an in-flight load is simply forgotten on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake and selection of what retires this cycle.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    fwd_valid  = 1'b0;
    capture_ld = 1'b0;
    retire_now = 1'b0;
    wb_wen     = in_wen;
    wb_rd      = in_rd;
    wb_pc      = in_pc;
    wb_data    = in_exu_res;
    wb_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_src == SRC_LOAD) begin
            capture_ld = 1'b1;
            state_nxt  = ST_WAIT_LD;
          end else begin
            retire_now = 1'b1;
            case (in_src)
              SRC_CSR: wb_data = in_csr_res;
              SRC_PC4: wb_data = in_pc + XLEN'(4);
              default: wb_data = in_exu_res;
            endcase
          end
        end
      end
      ST_WAIT_LD: begin
        fwd_valid = 1'b1;
        wb_wen    = ld_wen;
        wb_rd     = ld_rd;
        wb_pc     = ld_pc;
        wb_data   = ext_data;
        wb_err    = ext_illegal;
        if (lsu_rvalid) begin
          retire_now = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fwd_rd = fwd_valid ? ld_rd : '0;

  // Load context capture, registered writeback/retire outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd        <= '0;
      ld_wen       <= 1'b0;
      ld_pc        <= '0;
      ld_size      <= '0;
      ld_off       <= '0;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_cnt   <= '0;
      ld_err       <= 1'b0;
    end else begin
      rf_wen       <= 1'b0;
      retire_valid <= 1'b0;
      if (capture_ld) begin
        ld_rd   <= in_rd;
        ld_wen  <= in_wen;
        ld_pc   <= in_pc;
        ld_size <= in_ld_size;
        ld_off  <= in_ld_off;
      end
      if (retire_now) begin
        rf_wen       <= wb_wen && (wb_rd != '0);
        rf_waddr     <= wb_rd;
        rf_wdata     <= wb_data;
        retire_valid <= 1'b1;
        retire_pc    <= wb_pc;
        retire_cnt   <= retire_cnt + 1'b1;
        if (wb_err) ld_err <= 1'b1;
      end
    end
  end

endmodule
